// File: rtl/tmr_sfr_block_pkg.sv
// SFR layout shared by the timer SFR bank and its users.
// Holds the register field types, the bank offsets and the TMR_CTRL bit classes.
package pkg_sfrs_definition;

  typedef struct packed {
    logic [19:0] rsvd;
    logic        ovf_f;
    logic        match1_f;
    logic        match0_f;
    logic        ovf_en;
    logic        match1_en;
    logic        match0_en;
    logic        rd;
    logic        ld;
    logic        rst;
    logic        stop;
    logic        start;
    logic        on;
  } tmr_ctrl_t;

  typedef struct packed { logic [31:0] val; } tmr_val_t;
  typedef struct packed { logic [31:0] val; } tmr_match_val0_t;
  typedef struct packed { logic [31:0] val; } tmr_match_val1_t;

  localparam logic [11:0] TMR_CTRL_OFS       = 12'h000;
  localparam logic [11:0] TMR_VAL_OFS        = 12'h004;
  localparam logic [11:0] TMR_MATCH_VAL0_OFS = 12'h008;
  localparam logic [11:0] TMR_MATCH_VAL1_OFS = 12'h00C;

  localparam logic [31:0] TMR_CTRL_W1C_MASK  = 32'h0000_0E00;
  localparam logic [31:0] TMR_CTRL_IMPL_MASK = 32'h0000_0FFF;

  // Flags [11:9] line up bit-for-bit with their enables [8:6].
  localparam int TMR_CTRL_FLAG_LSB = 9;
  localparam int TMR_CTRL_EN_LSB   = 6;

endpackage

// File: rtl/tmr_sfr_block_reg_hw.sv
// One SFR with per-bit SW/HW merge: RW or W1C from software, per-bit HW update.
// HS_PRIO_MASK bits let a HW set survive a same-cycle SW clear.
module sfr_reg_hw #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] IMPL_MASK    = '1,
  parameter logic [DATA_WIDTH-1:0] W1C_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] HS_PRIO_MASK = '0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  sw_we,
  input  logic [DATA_WIDTH-1:0] sw_wdata,
  input  logic [DATA_WIDTH-1:0] hw_up,
  input  logic [DATA_WIDTH-1:0] hw_val,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] q_nxt;

  always_comb begin
    q_nxt = q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (!IMPL_MASK[i])
        q_nxt[i] = 1'b0;
      else if (HS_PRIO_MASK[i] && hw_up[i] && hw_val[i])
        q_nxt[i] = 1'b1;
      else if (sw_we && !W1C_MASK[i])
        q_nxt[i] = sw_wdata[i];
      else if (sw_we && sw_wdata[i])
        q_nxt[i] = 1'b0;
      else if (hw_up[i])
        q_nxt[i] = hw_val[i];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      q <= '0;
    else
      q <= q_nxt;
  end

endmodule

// File: rtl/tmr_sfr_block.sv
// Timer SFR bank: bus decode, four merged registers, registered read port and level irq.
// Reads return the value held before the same-cycle update.
module tmr_sfr_block
  import pkg_sfrs_definition::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h100
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  sfr_wr_en,
  input  logic                  sfr_rd_en,
  input  logic [ADDR_WIDTH-1:0] sfr_addr,
  input  logic [DATA_WIDTH-1:0] sfr_wdata,
  output logic [DATA_WIDTH-1:0] sfr_rdata,
  output logic                  sfr_rdata_vld,
  input  logic [DATA_WIDTH-1:0] hw_up_tmr_ctrl,
  input  logic [DATA_WIDTH-1:0] hw_up_tmr_val,
  input  logic [DATA_WIDTH-1:0] hw_up_tmr_match_val0,
  input  logic [DATA_WIDTH-1:0] hw_up_tmr_match_val1,
  input  logic [DATA_WIDTH-1:0] hw_val_tmr_ctrl,
  input  logic [DATA_WIDTH-1:0] hw_val_tmr_val,
  input  logic [DATA_WIDTH-1:0] hw_val_tmr_match_val0,
  input  logic [DATA_WIDTH-1:0] hw_val_tmr_match_val1,
  output logic [DATA_WIDTH-1:0] tmr_ctrl,
  output logic [DATA_WIDTH-1:0] tmr_val,
  output logic [DATA_WIDTH-1:0] tmr_match_val0,
  output logic [DATA_WIDTH-1:0] tmr_match_val1,
  output logic                  tmr_irq
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL = BASE_ADDR + ADDR_WIDTH'(TMR_CTRL_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_VAL  = BASE_ADDR + ADDR_WIDTH'(TMR_VAL_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MV0  = BASE_ADDR + ADDR_WIDTH'(TMR_MATCH_VAL0_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MV1  = BASE_ADDR + ADDR_WIDTH'(TMR_MATCH_VAL1_OFS);

  localparam logic [DATA_WIDTH-1:0] CTRL_IMPL = DATA_WIDTH'(TMR_CTRL_IMPL_MASK);
  localparam logic [DATA_WIDTH-1:0] CTRL_W1C  = DATA_WIDTH'(TMR_CTRL_W1C_MASK);

  logic hit_ctrl, hit_val, hit_mv0, hit_mv1;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic irq_nxt;

  assign hit_ctrl = (sfr_addr == ADDR_CTRL);
  assign hit_val  = (sfr_addr == ADDR_VAL);
  assign hit_mv0  = (sfr_addr == ADDR_MV0);
  assign hit_mv1  = (sfr_addr == ADDR_MV1);

  sfr_reg_hw #(
    .DATA_WIDTH  (DATA_WIDTH),
    .IMPL_MASK   (CTRL_IMPL),
    .W1C_MASK    (CTRL_W1C),
    .HS_PRIO_MASK(CTRL_W1C)
  ) u_ctrl (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .sw_we    (sfr_wr_en && hit_ctrl),
    .sw_wdata (sfr_wdata),
    .hw_up    (hw_up_tmr_ctrl),
    .hw_val   (hw_val_tmr_ctrl),
    .q        (tmr_ctrl)
  );

  sfr_reg_hw #(.DATA_WIDTH(DATA_WIDTH)) u_val (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .sw_we    (sfr_wr_en && hit_val),
    .sw_wdata (sfr_wdata),
    .hw_up    (hw_up_tmr_val),
    .hw_val   (hw_val_tmr_val),
    .q        (tmr_val)
  );

  sfr_reg_hw #(.DATA_WIDTH(DATA_WIDTH)) u_mv0 (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .sw_we    (sfr_wr_en && hit_mv0),
    .sw_wdata (sfr_wdata),
    .hw_up    (hw_up_tmr_match_val0),
    .hw_val   (hw_val_tmr_match_val0),
    .q        (tmr_match_val0)
  );

  sfr_reg_hw #(.DATA_WIDTH(DATA_WIDTH)) u_mv1 (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .sw_we    (sfr_wr_en && hit_mv1),
    .sw_wdata (sfr_wdata),
    .hw_up    (hw_up_tmr_match_val1),
    .hw_val   (hw_val_tmr_match_val1),
    .q        (tmr_match_val1)
  );

  always_comb begin
    rd_mux = '0;
    if (hit_ctrl)     rd_mux = tmr_ctrl;
    else if (hit_val) rd_mux = tmr_val;
    else if (hit_mv0) rd_mux = tmr_match_val0;
    else if (hit_mv1) rd_mux = tmr_match_val1;
  end

  assign irq_nxt = |(tmr_ctrl[TMR_CTRL_FLAG_LSB +: 3] & tmr_ctrl[TMR_CTRL_EN_LSB +: 3]);

  // rdata is forced to 0 outside the response cycle so consumers can OR-combine buses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sfr_rdata     <= '0;
      sfr_rdata_vld <= 1'b0;
      tmr_irq       <= 1'b0;
    end else begin
      sfr_rdata     <= sfr_rd_en ? rd_mux : '0;
      sfr_rdata_vld <= sfr_rd_en;
      tmr_irq       <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_tmr_sfr_block.sv
// Bench for tmr_sfr_block: directed literal checks plus random traffic against a register-level model.
module tb_tmr_sfr_block;

  localparam logic [11:0] BASE = 12'h100;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        wr_en, rd_en;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] up  [4];
  logic [31:0] val [4];
  logic [31:0] rdata;
  logic        vld, irq;
  logic [31:0] t_ctrl, t_val, t_mv0, t_mv1;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 sys_clk = ~sys_clk;

  tmr_sfr_block #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .BASE_ADDR(BASE)) dut (
    .sys_clk              (sys_clk),
    .sys_rst_n            (sys_rst_n),
    .sfr_wr_en            (wr_en),
    .sfr_rd_en            (rd_en),
    .sfr_addr             (addr),
    .sfr_wdata            (wdata),
    .sfr_rdata            (rdata),
    .sfr_rdata_vld        (vld),
    .hw_up_tmr_ctrl       (up[0]),
    .hw_up_tmr_val        (up[1]),
    .hw_up_tmr_match_val0 (up[2]),
    .hw_up_tmr_match_val1 (up[3]),
    .hw_val_tmr_ctrl      (val[0]),
    .hw_val_tmr_val       (val[1]),
    .hw_val_tmr_match_val0(val[2]),
    .hw_val_tmr_match_val1(val[3]),
    .tmr_ctrl             (t_ctrl),
    .tmr_val              (t_val),
    .tmr_match_val0       (t_mv0),
    .tmr_match_val1       (t_mv1),
    .tmr_irq              (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register-level reference: apply HW updates, then let a SW write override
  // plain bits; W1C flags clear unless HW is setting them in the same cycle.
  logic [31:0] m_reg [4] = '{default: '0};
  logic [31:0] m_rdata = '0;
  logic        m_vld = 1'b0;
  logic        m_irq = 1'b0;

  always @(posedge sys_clk or negedge sys_rst_n) begin : model
    logic [31:0] old [4];
    logic [31:0] nv, w1c, impl;
    int hit;
    if (!sys_rst_n) begin
      m_reg   = '{default: '0};
      m_rdata = '0;
      m_vld   = 1'b0;
      m_irq   = 1'b0;
    end else begin
      old = m_reg;
      hit = -1;
      for (int r = 0; r < 4; r++)
        if (addr == BASE + 12'(4 * r)) hit = r;
      m_vld   = rd_en;
      m_rdata = (rd_en && hit >= 0) ? old[hit] : 32'h0;
      m_irq   = |(old[0][11:9] & old[0][8:6]);
      for (int r = 0; r < 4; r++) begin
        w1c  = (r == 0) ? 32'h0000_0E00 : 32'h0;
        impl = (r == 0) ? 32'h0000_0FFF : 32'hFFFF_FFFF;
        nv = (old[r] & ~up[r]) | (val[r] & up[r]);
        if (wr_en && hit == r) begin
          nv = (nv & w1c) | (wdata & ~w1c);
          nv = nv & ~(wdata & w1c & ~(up[r] & val[r]));
        end
        m_reg[r] = nv & impl;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (chk_on) begin
      chk("cmp_tmr_ctrl", t_ctrl, m_reg[0]);
      chk("cmp_tmr_val",  t_val,  m_reg[1]);
      chk("cmp_tmr_mv0",  t_mv0,  m_reg[2]);
      chk("cmp_tmr_mv1",  t_mv1,  m_reg[3]);
      chk("cmp_rdata",    rdata,  m_rdata);
      chk("cmp_vld",      32'(vld), 32'(m_vld));
      chk("cmp_irq",      32'(irq), 32'(m_irq));
    end
  end

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    for (int r = 0; r < 4; r++) begin up[r] = '0; val[r] = '0; end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [11:0] a);
    rd_en = 1'b1; addr = a;
    step();
    idle();
  endtask

  initial begin
    idle();
    #2 sys_rst_n = 1'b0;
    repeat (3) step();
    sys_rst_n = 1'b1;
    chk_on = 1'b1;

    chk("rst_irq", 32'(irq), 0);
    for (int r = 0; r < 4; r++) begin
      rd(BASE + 12'(4 * r));
      chk("rst_rd_vld", 32'(vld), 1);
      chk("rst_rd_data", rdata, 0);
      step();
      chk("vld_one_cycle", 32'(vld), 0);
    end

    wr(BASE, 32'hFFFF_FFFF);
    chk("ctrl_all_ones_out", t_ctrl, 32'h0000_01FF);
    rd(BASE);
    chk("ctrl_all_ones_rd", rdata, 32'h0000_01FF);

    up[0][9] = 1'b1; val[0][9] = 1'b1;
    step();
    idle();
    chk("match0_f_set", 32'(t_ctrl[9]), 1);
    chk("irq_not_yet", 32'(irq), 0);
    step();
    chk("irq_rise", 32'(irq), 1);
    wr(BASE, 32'h0000_0200);
    chk("match0_f_w1c", 32'(t_ctrl[9]), 0);
    chk("irq_hold", 32'(irq), 1);
    step();
    chk("irq_fall", 32'(irq), 0);

    up[0][11] = 1'b1; val[0][11] = 1'b1;
    wr(BASE, 32'h0000_0800);
    chk("ovf_hs_beats_w1c", t_ctrl, 32'h0000_0800);
    up[0][1] = 1'b1; val[0][1] = 1'b0;
    wr(BASE, 32'h0000_0002);
    chk("sw_start_beats_hc", t_ctrl, 32'h0000_0802);
    step();

    up[1] = '1; val[1] = 32'h0000_1234;
    step();
    idle();
    rd(BASE + 12'h4);
    chk("snapshot", rdata, 32'h0000_1234);
    up[1] = '1; val[1] = 32'h0000_1234;
    wr(BASE + 12'h4, 32'h0000_0055);
    rd(BASE + 12'h4);
    chk("snapshot_sw_wins", rdata, 32'h0000_0055);

    wr(BASE + 12'h8, 32'h0000_0077);
    wr_en = 1'b1; rd_en = 1'b1; addr = BASE + 12'h8; wdata = 32'h0000_DEAD;
    step();
    idle();
    chk("rdw_old_value", rdata, 32'h0000_0077);
    rd(BASE + 12'h8);
    chk("rdw_new_value", rdata, 32'h0000_DEAD);

    rd_en = 1'b1; addr = BASE + 12'h8;
    #2 sys_rst_n = 1'b0;
    step();
    idle();
    chk("rst_mid_vld", 32'(vld), 0);
    chk("rst_mid_rdata", rdata, 0);
    chk("rst_mid_mv0", t_mv0, 0);
    chk("rst_mid_ctrl", t_ctrl, 0);
    chk("rst_mid_irq", 32'(irq), 0);
    sys_rst_n = 1'b1;
    step();

    repeat (1500) begin
      wr_en = ($urandom_range(2) == 0);
      rd_en = ($urandom_range(2) == 0);
      addr  = ($urandom_range(4) == 0) ? 12'($urandom) : BASE + 12'(4 * $urandom_range(3));
      wdata = $urandom;
      for (int r = 0; r < 4; r++) begin
        up[r]  = ($urandom_range(3) == 0) ? ($urandom & $urandom) : 32'h0;
        if ($urandom_range(15) == 0) up[r] = '1;
        val[r] = $urandom;
      end
      step();
    end
    idle();
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
